// File: rtl/abcd_pkg.sv
// abcd_pkg -- shared definitions for the ABCD serial deserializer.
//
// Holds the FSM state encoding, the number of reassembled words and the
// default widths used by abcd_deserializer and its sub-module.
//
// Optional feature macro: PARITY_CHECK_EN (adds the PARITY state).

package abcd_pkg;

    localparam int NUM_WORDS  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Fixed encoding so the debug state output stays stable across builds,
    // whether or not the PARITY state is compiled in.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
`ifdef PARITY_CHECK_EN
        PARITY    = 3'd2,
`endif
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

endpackage

// File: rtl/abcd_shift_reg.sv
// abcd_shift_reg -- MSB-first serial-in/parallel-out shift register.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset, clears contents
//   clr_i      in   synchronous clear (wins over shift_en_i)
//   shift_en_i in   shift sin_i into the LSB, older bits move toward the MSB
//   sin_i      in   serial data bit
//   data_o     out  WIDTH-bit parallel contents; the first bit shifted in
//                   ends up in the MSB after WIDTH shifts

module abcd_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (shift_en_i) begin
            data_d = {data_q[WIDTH-2:0], sin_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/abcd_deserializer.sv
// abcd_deserializer -- receives a framed serial word group and reassembles
// four DATA_W-bit words A, B, C, D.
//
// Frame on sin (one bit per clk, line idles high):
//   start 0, 4*DATA_W data bits (A first, D last, each MSB first),
//   [even parity bit when PARITY_CHECK_EN is defined], stop 1.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   -> PARITY state present, parity_err reports even-parity errors
//   undefined -> no parity bit in the frame, parity_err is constant 0
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-high reset
//   sin        in   serial line
//   A,B,C,D    out  words of the last good frame (held between frames)
//   valid      out  one-cycle strobe, A..D updated; there is no ready --
//                   the consumer must take the words while they are held
//   frame_err  out  one-cycle strobe, stop bit sampled as 0
//   parity_err out  one-cycle strobe, parity mismatch with a good stop bit
//   frame_cnt  out  count of good frames, wraps silently
//   state_dbg  out  current FSM state (abcd_pkg::state_t encoding)

module abcd_deserializer
    import abcd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic [DATA_W-1:0] D,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [2:0]        state_dbg
);

    localparam int FRAME_BITS = NUM_WORDS * DATA_W;
    localparam int BCW        = $clog2(FRAME_BITS);

    state_t                  state_q, state_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   words_q, words_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    sr_clr;
    logic                    sr_shift;
    logic [FRAME_BITS-1:0]   sr_data;
    logic                    last_bit;
`ifdef PARITY_CHECK_EN
    logic                    perr_q, perr_d;
    logic                    par_bad_q, par_bad_d;
`endif

    abcd_shift_reg #(
        .WIDTH (FRAME_BITS)
    ) u_shift_reg (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (sr_clr),
        .shift_en_i (sr_shift),
        .sin_i      (sin),
        .data_o     (sr_data)
    );

    assign last_bit = (bit_cnt_q == BCW'(FRAME_BITS - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        words_d   = words_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        sr_clr    = 1'b0;
        sr_shift  = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (!sin) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    sr_clr    = 1'b1;
`ifdef PARITY_CHECK_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            DATA: begin
                sr_shift  = 1'b1;
                bit_cnt_d = bit_cnt_q + BCW'(1);
                if (last_bit) begin
`ifdef PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                // Even parity: data bits plus parity bit must XOR to 0.
                par_bad_d = sin ^ (^sr_data);
                state_d   = STOP;
            end
`endif
            STOP: begin
                // A bad stop bit outranks a parity mismatch.
                if (!sin) begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end
`ifdef PARITY_CHECK_EN
                else if (par_bad_q) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
                else begin
                    words_d = sr_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: begin
                // A broken frame leaves the line low; a new start bit is
                // only trusted once the line has returned to idle.
                if (sin) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            words_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            words_q   <= words_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef PARITY_CHECK_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign A          = words_q[4*DATA_W-1 -: DATA_W];
    assign B          = words_q[3*DATA_W-1 -: DATA_W];
    assign C          = words_q[2*DATA_W-1 -: DATA_W];
    assign D          = words_q[DATA_W-1   -: DATA_W];
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
    assign frame_cnt  = cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_abcd_deserializer.sv
// tb_abcd_deserializer -- self-checking bench for abcd_deserializer.
// Frames are built bit by bit from 32-bit word groups; the expected outcome
// of each frame (good / frame error / parity error) and the resulting A..D
// and frame count come from the frame contents alone.

`timescale 1ns/1ps

module tb_abcd_deserializer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;   // small counter so the wrap is reached

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              sin;
    logic [DATA_W-1:0] A, B, C, D;
    logic              valid, frame_err, parity_err;
    logic [CNT_W-1:0]  frame_cnt;
    logic [2:0]        state_dbg;

    always #5 clk = ~clk;

    abcd_deserializer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .frame_cnt  (frame_cnt),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int               due;     // cycle in which the strobe must be seen
        logic [2:0]       pulses;  // {valid, frame_err, parity_err}
        logic [31:0]      words;   // expected {A,B,C,D} in that cycle
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [31:0]      m_words;
    logic [CNT_W-1:0] m_cnt;
    int               cyc   = 0;
    int               total = 0;
    int               bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every cycle, just after the rising edge, the strobes must be
    // exactly what the scoreboard predicts for that cycle.
    exp_t       mon_e;
    logic       mon_has;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            mon_has = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                check_eq("missed_event", 64'(cyc), 64'(mon_e.due));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e   = exp_q.pop_front();
                mon_has = 1'b1;
            end
            if (mon_has) begin
                check_eq("pulses", {valid, frame_err, parity_err}, mon_e.pulses);
                check_eq("words", {A, B, C, D}, mon_e.words);
                check_eq("frame_cnt", frame_cnt, mon_e.cnt);
            end else begin
                check_eq("pulses_idle", {valid, frame_err, parity_err}, 3'b000);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Sends one complete frame; par_flip inverts the correct parity bit.
    task automatic send_frame(input logic [31:0] w, input logic par_flip, input logic stop_b);
        exp_t e;
        logic par_ok;
        drive_bit(1'b0);
        for (int i = 31; i >= 0; i--) drive_bit(w[i]);
`ifdef PARITY_CHECK_EN
        drive_bit((^w) ^ par_flip);
        par_ok = !par_flip;
`else
        par_ok = 1'b1;
`endif
        drive_bit(stop_b);
        e.due = cyc + 1;
        if (!stop_b) begin
            e.pulses = 3'b010;
        end else if (!par_ok) begin
            e.pulses = 3'b001;
        end else begin
            e.pulses = 3'b100;
            m_words  = w;
            m_cnt    = m_cnt + 1'b1;
        end
        e.words = m_words;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_words"}, {A, B, C, D}, 32'h0);
        check_eq({tag, "_cnt"}, frame_cnt, '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    int  gap;
    logic stop_b;
    logic flip;

    initial begin
        m_words = '0;
        m_cnt   = '0;
        sin     = 1'b1;
        reset   = 1'b1;
        #20;
        reset   = 1'b0;

        // Idle line after reset: nothing happens, outputs stay cleared.
        idle(5);
        check_reset_state("reset");

        // Single good frame.
        send_frame(32'h12345678, 1'b0, 1'b1);
        idle(3);

        // Bad stop bit, line held low, then released; next good frame
        // proves no start was taken while the line was low.
        send_frame(32'h12345678, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        idle(2);
        check_eq("hold_words", {A, B, C, D}, 32'h12345678);

`ifdef PARITY_CHECK_EN
        // Wrong parity bit (0 while one data bit is set).
        send_frame(32'h01000000, 1'b1, 1'b1);
        idle(2);
`endif

        // Back-to-back frames.
        send_frame(32'hAABBCCDD, 1'b0, 1'b1);
        send_frame(32'h11223344, 1'b0, 1'b1);
        idle(3);
        check_eq("b2b_words", {A, B, C, D}, 32'h11223344);

        // Reset at data bit 10 discards the frame.
        drive_bit(1'b0);
        for (int i = 0; i < 10; i++) drive_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        reset = 1'b1;
        sin   = 1'b1;
        m_words = '0;
        m_cnt   = '0;
        idle(2);
        reset = 1'b0;
        idle(2);
        check_reset_state("midreset");
        send_frame(32'hCAFEF00D, 1'b0, 1'b1);
        idle(2);

        // Randomized frames: random data, occasional bad stop or parity,
        // random idle gaps including none; count wraps along the way.
        for (int n = 0; n < 40; n++) begin
            stop_b = ($urandom_range(0, 7) != 0);
`ifdef PARITY_CHECK_EN
            flip   = ($urandom_range(0, 5) == 0);
`else
            flip   = 1'b0;
`endif
            send_frame($urandom, flip, stop_b);
            if (!stop_b) begin
                gap = $urandom_range(0, 4);
                for (int i = 0; i < gap; i++) drive_bit(1'b0);
                drive_bit(1'b1);
            end
            gap = $urandom_range(0, 2);
            idle(gap);
        end

        idle(4);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
